// File: rtl/film_feature_extract.sv
// Per-frame bright/dark pixel counter feeding the film decision tree; all logic on cam_pclk.
// Optional region-of-interest gating is enabled by defining FEATURE_ROI_EN.
module film_feature_extract #(
    parameter int PIX_W  = 8,
    parameter int THR_HI = 200,
    parameter int THR_LO = 40,
    parameter int ROI_X0 = 0,
    parameter int ROI_X1 = 639,
    parameter int ROI_Y0 = 0,
    parameter int ROI_Y1 = 479
) (
    input  logic             cam_pclk,
    input  logic             rst,
    input  logic             cam_vsync,
    input  logic             cam_href,
    input  logic             cam_de,
    input  logic [PIX_W-1:0] cam_gray,
    output logic [19:0]      feature0,
    output logic [19:0]      feature1,
    output logic             lable_start,
    output logic [7:0]       frame_done_cnt
);

    typedef enum logic [1:0] {SYNC, ACTIVE, LATCH, WAIT} state_t;

    localparam logic [PIX_W-1:0] THR_HI_W = THR_HI[PIX_W-1:0];
    localparam logic [PIX_W-1:0] THR_LO_W = THR_LO[PIX_W-1:0];

    state_t      state_q, state_d;
    logic        vs_dly_q, hr_dly_q;
    logic [19:0] acc0_q, acc0_d, acc1_q, acc1_d;
    logic [19:0] feature0_q, feature0_d, feature1_q, feature1_d;
    logic        lable_start_q, lable_start_d;
    logic [7:0]  frame_done_cnt_q, frame_done_cnt_d;

    logic vs_rise, vs_fall, href_fall, pix_valid, pix_ok, roi_hit, bright, dark;

    assign vs_rise   = cam_vsync & ~vs_dly_q;
    assign vs_fall   = ~cam_vsync & vs_dly_q;
    assign href_fall = ~cam_href & hr_dly_q;
    assign pix_valid = cam_href & cam_de & ~cam_vsync & (state_q == ACTIVE);
    assign pix_ok    = pix_valid & roi_hit;
    // Bright takes precedence so a pixel is never counted twice.
    assign bright    = cam_gray > THR_HI_W;
    assign dark      = ~bright & (cam_gray <= THR_LO_W);

`ifdef FEATURE_ROI_EN
    localparam logic [10:0] ROI_X0_W = ROI_X0[10:0];
    localparam logic [10:0] ROI_X1_W = ROI_X1[10:0];
    localparam logic [9:0]  ROI_Y0_W = ROI_Y0[9:0];
    localparam logic [9:0]  ROI_Y1_W = ROI_Y1[9:0];

    logic [10:0] col_q, col_d;
    logic [9:0]  row_q, row_d;

    assign roi_hit = (col_q >= ROI_X0_W) && (col_q <= ROI_X1_W) &&
                     (row_q >= ROI_Y0_W) && (row_q <= ROI_Y1_W);

    // Position counters track every valid pixel, inside the ROI or not.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (state_q == LATCH) begin
            col_d = '0;
            row_d = '0;
        end else begin
            if (href_fall)
                col_d = '0;
            else if (pix_valid && (col_q != '1))
                col_d = col_q + 11'd1;
            if (href_fall && (state_q == ACTIVE) && (row_q != '1))
                row_d = row_q + 10'd1;
        end
    end

    always_ff @(posedge cam_pclk or posedge rst) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end
`else
    assign roi_hit = 1'b1;
`endif

    always_comb begin
        state_d          = state_q;
        feature0_d       = feature0_q;
        feature1_d       = feature1_q;
        lable_start_d    = 1'b0;
        frame_done_cnt_d = frame_done_cnt_q;
        acc0_d           = acc0_q;
        acc1_d           = acc1_q;
        if (pix_ok && bright && (acc0_q != '1))
            acc0_d = acc0_q + 20'd1;
        if (pix_ok && dark && (acc1_q != '1))
            acc1_d = acc1_q + 20'd1;
        case (state_q)
            SYNC:   if (vs_fall) state_d = ACTIVE;
            ACTIVE: if (vs_rise) state_d = LATCH;
            LATCH: begin
                state_d          = WAIT;
                feature0_d       = acc0_q;
                feature1_d       = acc1_q;
                lable_start_d    = 1'b1;
                frame_done_cnt_d = frame_done_cnt_q + 8'd1;
                acc0_d           = '0;
                acc1_d           = '0;
            end
            WAIT:   if (vs_fall) state_d = ACTIVE;
            default: state_d = SYNC;
        endcase
    end

    always_ff @(posedge cam_pclk or posedge rst) begin
        if (rst) begin
            state_q          <= SYNC;
            vs_dly_q         <= 1'b0;
            hr_dly_q         <= 1'b0;
            acc0_q           <= '0;
            acc1_q           <= '0;
            feature0_q       <= '0;
            feature1_q       <= '0;
            lable_start_q    <= 1'b0;
            frame_done_cnt_q <= '0;
        end else begin
            state_q          <= state_d;
            vs_dly_q         <= cam_vsync;
            hr_dly_q         <= cam_href;
            acc0_q           <= acc0_d;
            acc1_q           <= acc1_d;
            feature0_q       <= feature0_d;
            feature1_q       <= feature1_d;
            lable_start_q    <= lable_start_d;
            frame_done_cnt_q <= frame_done_cnt_d;
        end
    end

    assign feature0       = feature0_q;
    assign feature1       = feature1_q;
    assign lable_start    = lable_start_q;
    assign frame_done_cnt = frame_done_cnt_q;

endmodule

// File: tb/tb_film_feature_extract.sv
// Randomized self-checking bench for film_feature_extract; pixel counts come from a frame-level model.
// Build with FEATURE_ROI_EN defined to exercise the ROI window (cols/rows 1..2).
module tb_film_feature_extract;

    localparam int THR_HI = 200;
    localparam int THR_LO = 40;
    localparam int SAT    = 20'hFFFFF;

    logic        cam_pclk = 1'b0;
    logic        rst;
    logic        cam_vsync;
    logic        cam_href;
    logic        cam_de;
    logic [7:0]  cam_gray;
    logic [19:0] feature0;
    logic [19:0] feature1;
    logic        lable_start;
    logic [7:0]  frame_done_cnt;

    int         n_cmp = 0;
    int         n_err = 0;
    int         exp0;
    int         exp1;
    logic [7:0] exp_cnt;
    int         pix_q[$];
    int         specials[6] = '{0, 40, 41, 200, 201, 255};

    always #5 cam_pclk = ~cam_pclk;

    film_feature_extract #(
        .PIX_W(8), .THR_HI(THR_HI), .THR_LO(THR_LO),
        .ROI_X0(1), .ROI_X1(2), .ROI_Y0(1), .ROI_Y1(2)
    ) dut (
        .cam_pclk(cam_pclk),
        .rst(rst),
        .cam_vsync(cam_vsync),
        .cam_href(cam_href),
        .cam_de(cam_de),
        .cam_gray(cam_gray),
        .feature0(feature0),
        .feature1(feature1),
        .lable_start(lable_start),
        .frame_done_cnt(frame_done_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge cam_pclk);
        #1;
    endtask

    function automatic bit in_roi(input int r, input int c);
`ifdef FEATURE_ROI_EN
        return (r >= 1) && (r <= 2) && (c >= 1) && (c <= 2);
`else
        return (r >= 0) && (c >= 0);
`endif
    endfunction

    task automatic fill_const(input int n, input int g);
        for (int i = 0; i < n; i++) pix_q.push_back(g);
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(1) == 0) pix_q.push_back(int'($urandom_range(255)));
            else pix_q.push_back(specials[$urandom_range(5)]);
        end
    endtask

    // Streams rows x cols pixels from pix_q, scoring each valid pixel by its in-frame position.
    task automatic run_lines(input int rows, input int cols, input int de_pct);
        for (int r = 0; r < rows; r++) begin
            int c_valid = 0;
            for (int k = 0; k < cols; k++) begin
                int g = pix_q.pop_front();
                bit de = (int'($urandom_range(99)) < de_pct);
                cam_href = 1'b1;
                cam_de   = de;
                cam_gray = 8'(g);
                if (de) begin
                    if (in_roi(r, c_valid)) begin
                        if (g > THR_HI) exp0++;
                        else if (g <= THR_LO) exp1++;
                    end
                    c_valid++;
                end
                tick();
            end
            cam_href = 1'b0;
            cam_de   = 1'b0;
            tick();
            tick();
        end
    endtask

    task automatic start_frame();
        exp0 = 0;
        exp1 = 0;
        cam_vsync = 1'b0;
        repeat (3) tick();
    endtask

    task automatic end_frame(input string tag);
        if (exp0 > SAT) exp0 = SAT;
        if (exp1 > SAT) exp1 = SAT;
        cam_vsync = 1'b1;
        cam_href  = 1'b0;
        cam_de    = 1'b0;
        tick();
        chk({tag, "_ls_early"}, 32'(lable_start), 32'd0);
        tick();
        exp_cnt = exp_cnt + 8'd1;
        chk({tag, "_ls_pulse"}, 32'(lable_start), 32'd1);
        chk({tag, "_f0"}, 32'(feature0), 32'(exp0));
        chk({tag, "_f1"}, 32'(feature1), 32'(exp1));
        chk({tag, "_cnt"}, 32'(frame_done_cnt), 32'(exp_cnt));
        tick();
        chk({tag, "_ls_fall"}, 32'(lable_start), 32'd0);
        chk({tag, "_f0_hold"}, 32'(feature0), 32'(exp0));
        tick();
        tick();
    endtask

    initial begin
        bit saw;
        rst       = 1'b1;
        cam_vsync = 1'b1;
        cam_href  = 1'b0;
        cam_de    = 1'b0;
        cam_gray  = '0;
        exp_cnt   = '0;
        repeat (3) tick();
        chk("rst_f0", 32'(feature0), 32'd0);
        chk("rst_f1", 32'(feature1), 32'd0);
        chk("rst_ls", 32'(lable_start), 32'd0);
        chk("rst_cnt", 32'(frame_done_cnt), 32'd0);
        rst = 1'b0;
        repeat (2) tick();

        start_frame();
        fill_const(16, 255);
        run_lines(4, 4, 100);
        end_frame("bright4x4");

        // Threshold boundaries: 200 is not bright, 40 is dark, 201 is bright.
        for (int i = 0; i < 6; i++) pix_q.push_back(10);
        for (int i = 0; i < 5; i++) pix_q.push_back(201);
        for (int i = 0; i < 5; i++) pix_q.push_back(200);
        for (int i = 15; i > 0; i--) begin
            int j = int'($urandom_range(i));
            int t = pix_q[i];
            pix_q[i] = pix_q[j];
            pix_q[j] = t;
        end
        start_frame();
        run_lines(4, 4, 100);
        end_frame("mixed");

        start_frame();
        fill_const(16, 40);
        run_lines(4, 4, 100);
        end_frame("dark_edge");

        start_frame();
        fill_const(16, 255);
        run_lines(4, 4, 0);
        end_frame("empty");

        for (int f = 0; f < 6; f++) begin
            int rows = int'($urandom_range(1, 5));
            int cols = int'($urandom_range(1, 8));
            fill_random(rows * cols);
            start_frame();
            run_lines(rows, cols, 75);
            end_frame("rnd");
        end

        start_frame();
        force dut.acc0_q = 20'hFFFFD;
        tick();
        release dut.acc0_q;
        exp0 = 20'hFFFFD;
        fill_const(16, 255);
        run_lines(4, 4, 100);
        end_frame("sat");

        start_frame();
        fill_const(8, 255);
        run_lines(2, 4, 100);
        rst = 1'b1;
        #1;
        chk("rst_async_f0", 32'(feature0), 32'd0);
        chk("rst_async_cnt", 32'(frame_done_cnt), 32'd0);
        tick();
        rst = 1'b0;
        exp_cnt = '0;
        tick();
        fill_const(8, 255);
        run_lines(2, 4, 100);
        cam_vsync = 1'b1;
        saw = 1'b0;
        repeat (6) begin
            tick();
            if (lable_start) saw = 1'b1;
        end
        chk("rst_no_pulse", 32'(saw), 32'd0);
        chk("rst_f0_zero", 32'(feature0), 32'd0);

        start_frame();
        fill_const(4, 0);
        run_lines(2, 2, 100);
        end_frame("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
